// File: rtl/clock_gen_unit.sv
// clock_gen_unit: derives divided clocks from clk_in.
// Outputs are /2, /4, /8, /16 and /28 (50% duty), an odd /5 with 50% duty,
// and an 8-bit demo counter that steps +2 per cycle and -5 every 4th cycle.
// All state is cleared by the asynchronous active-low reset rst.
module clock_gen_unit (
   input  logic       clk_in,
   input  logic       rst,
   output logic       clk_div_2,
   output logic       clk_div_4,
   output logic       clk_div_8,
   output logic       clk_div_16,
   output logic       clk_div_28,
   output logic       clk_div_5,
   output logic [7:0] glitchy_counter
);

   logic [3:0] cnt16;
   logic [3:0] cnt14;
   logic       div28_q;
   logic [2:0] cnt5;
   logic       pos_t;
   logic       neg_t;
   logic       strobe;

   // Once every four cycles, the last cycle of each group of four is the
   // strobe that pulls the demo counter back by 5.
   assign strobe = (cnt16[1:0] == 2'b11);

   // Free-running 4-bit counter; each bit is one power-of-two divided clock.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         cnt16 <= 4'd0;
      end else begin
         cnt16 <= cnt16 + 4'd1;
      end
   end

   // Count 0..13 and toggle the /28 output on every wrap.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         cnt14   <= 4'd0;
         div28_q <= 1'b0;
      end else if (cnt14 == 4'd13) begin
         cnt14   <= 4'd0;
         div28_q <= ~div28_q;
      end else begin
         cnt14   <= cnt14 + 4'd1;
      end
   end

   // Count 0..4 (stray values 5..7 fall back to 0) and toggle pos_t on the wrap.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         cnt5  <= 3'd0;
         pos_t <= 1'b0;
      end else begin
         if (cnt5 >= 3'd4) begin
            cnt5 <= 3'd0;
         end else begin
            cnt5 <= cnt5 + 3'd1;
         end
         if (cnt5 == 3'd4) begin
            pos_t <= ~pos_t;
         end
      end
   end

   // Falling-edge toggle half a cycle into the count. XOR with pos_t gives
   // the 2.5-cycle high phase.
   always_ff @(negedge clk_in or negedge rst) begin
      if (!rst) begin
         neg_t <= 1'b0;
      end else if (cnt5 == 3'd2) begin
         neg_t <= ~neg_t;
      end
   end

   // Demo counter that steps +2 normally and -5 on the strobe, wrapping mod 256.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         glitchy_counter <= 8'd0;
      end else if (strobe) begin
         glitchy_counter <= glitchy_counter - 8'd5;
      end else begin
         glitchy_counter <= glitchy_counter + 8'd2;
      end
   end

   assign clk_div_2  = cnt16[0];
   assign clk_div_4  = cnt16[1];
   assign clk_div_8  = cnt16[2];
   assign clk_div_16 = cnt16[3];
   assign clk_div_28 = div28_q;
   assign clk_div_5  = pos_t ^ neg_t;

endmodule

// File: tb/tb_clock_gen_unit.sv
// tb_clock_gen_unit: checks clock_gen_unit in two ways. A fixed table of
// expected values is checked at chosen edges after reset release. An
// arithmetic reference model is evaluated at every half cycle, across a long
// run and across randomly timed asynchronous resets.
module tb_clock_gen_unit;

   logic       clk_in = 1'b0;
   logic       rst;
   logic       clk_div_2;
   logic       clk_div_4;
   logic       clk_div_8;
   logic       clk_div_16;
   logic       clk_div_28;
   logic       clk_div_5;
   logic [7:0] glitchy_counter;

   int compared   = 0;
   int mismatched = 0;
   int n          = 0;

   typedef struct {
      int         edge_num;
      logic       d2;
      logic       d4;
      logic       d8;
      logic       d16;
      logic       d28;
      logic       d5;
      logic [7:0] gc;
   } vec_t;

   vec_t tbl[12];

   clock_gen_unit dut (
      .clk_in          (clk_in),
      .rst             (rst),
      .clk_div_2       (clk_div_2),
      .clk_div_4       (clk_div_4),
      .clk_div_8       (clk_div_8),
      .clk_div_16      (clk_div_16),
      .clk_div_28      (clk_div_28),
      .clk_div_5       (clk_div_5),
      .glitchy_counter (glitchy_counter)
   );

   // 20 ns source clock.
   initial forever #10 clk_in = ~clk_in;

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model. n is the number of rising edges since reset release.
   // h counts half cycles: 2n just after edge n, 2n+1 after the falling edge
   // that follows it.
   function automatic logic [7:0] model_gc(int e);
      int v;
      v = 2 * e - 7 * (e / 4);
      return 8'(v % 256);
   endfunction

   function automatic logic model_pow2(int e, int half);
      return 1'((e / half) % 2);
   endfunction

   function automatic logic model_d5(int h);
      return ((h % 10) >= 5);
   endfunction

   task automatic check_output(input int h);
      cmp($sformatf("div2@h%0d", h),  {7'd0, clk_div_2},  {7'd0, model_pow2(n, 1)});
      cmp($sformatf("div4@h%0d", h),  {7'd0, clk_div_4},  {7'd0, model_pow2(n, 2)});
      cmp($sformatf("div8@h%0d", h),  {7'd0, clk_div_8},  {7'd0, model_pow2(n, 4)});
      cmp($sformatf("div16@h%0d", h), {7'd0, clk_div_16}, {7'd0, model_pow2(n, 8)});
      cmp($sformatf("div28@h%0d", h), {7'd0, clk_div_28}, {7'd0, model_pow2(n, 14)});
      cmp($sformatf("div5@h%0d", h),  {7'd0, clk_div_5},  {7'd0, model_d5(h)});
      cmp($sformatf("gcnt@h%0d", h),  glitchy_counter,    model_gc(n));
   endtask

   task automatic check_table();
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].edge_num == n) begin
            cmp($sformatf("tbl_div2@e%0d", n),  {7'd0, clk_div_2},  {7'd0, tbl[i].d2});
            cmp($sformatf("tbl_div4@e%0d", n),  {7'd0, clk_div_4},  {7'd0, tbl[i].d4});
            cmp($sformatf("tbl_div8@e%0d", n),  {7'd0, clk_div_8},  {7'd0, tbl[i].d8});
            cmp($sformatf("tbl_div16@e%0d", n), {7'd0, clk_div_16}, {7'd0, tbl[i].d16});
            cmp($sformatf("tbl_div28@e%0d", n), {7'd0, clk_div_28}, {7'd0, tbl[i].d28});
            cmp($sformatf("tbl_div5@e%0d", n),  {7'd0, clk_div_5},  {7'd0, tbl[i].d5});
            cmp($sformatf("tbl_gcnt@e%0d", n),  glitchy_counter,    tbl[i].gc);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      cmp({tag, "_div2"},  {7'd0, clk_div_2},  8'd0);
      cmp({tag, "_div4"},  {7'd0, clk_div_4},  8'd0);
      cmp({tag, "_div8"},  {7'd0, clk_div_8},  8'd0);
      cmp({tag, "_div16"}, {7'd0, clk_div_16}, 8'd0);
      cmp({tag, "_div28"}, {7'd0, clk_div_28}, 8'd0);
      cmp({tag, "_div5"},  {7'd0, clk_div_5},  8'd0);
      cmp({tag, "_gcnt"},  glitchy_counter,    8'd0);
   endtask

   // Run edges, sampling 5 ns after each rising and each falling edge.
   task automatic apply_stimulus(input int count);
      repeat (count) begin
         @(posedge clk_in);
         n++;
         #5;
         check_output(2 * n);
         check_table();
         @(negedge clk_in);
         #5;
         check_output(2 * n + 1);
      end
   endtask

   // Release reset in the middle of the low phase, so the next rising edge is edge 1.
   task automatic release_reset();
      @(negedge clk_in);
      #5;
      rst = 1'b1;
      n   = 0;
   endtask

   // Assert reset between clock edges, in either phase, and expect zeros at once.
   task automatic assert_reset_mid();
      if ($urandom_range(0, 1) == 1) begin
         @(posedge clk_in);
         #($urandom_range(2, 8));
      end else begin
         #($urandom_range(1, 4));
      end
      rst = 1'b0;
      #1;
      check_zero("async_rst");
      repeat ($urandom_range(1, 5)) begin
         @(posedge clk_in);
         #5;
         check_zero("rst_held");
      end
   endtask

   initial begin
      tbl[0]  = '{1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
      tbl[1]  = '{2,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
      tbl[2]  = '{3,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6};
      tbl[3]  = '{4,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
      tbl[4]  = '{8,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2};
      tbl[5]  = '{13,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5};
      tbl[6]  = '{14,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd7};
      tbl[7]  = '{15,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd9};
      tbl[8]  = '{16,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4};
      tbl[9]  = '{27,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd12};
      tbl[10] = '{28,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd7};
      tbl[11] = '{256, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd64};

      rst = 1'b0;
      #5;
      check_zero("por");
      #20;
      check_zero("por_hold");
      release_reset();

      // Long run: passes edge 256 and wraps the demo counter through 255 -> 0.
      apply_stimulus(1100);

      // Random asynchronous resets; each restart must match power-up behaviour.
      for (int r = 0; r < 6; r++) begin
         assert_reset_mid();
         release_reset();
         apply_stimulus($urandom_range(20, 300));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
